// File: rtl/ram_port_arbiter_pkg.sv
// Shared widths, FSM state codes and helpers for the two-requester RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 24;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Saturating increment used by the optional grant counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_port_arbiter.
// Handshake: a requester holds req with we/addr/wdata stable until it sees its one-cycle gnt
// pulse; a read's data follows as a one-cycle rvalid pulse on the next cycle.
interface ram_port_arbiter_if;
  import ram_port_arbiter_pkg::*;

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           ram_addr, ram_we, ram_re, ram_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           ram_addr, ram_we, ram_re, ram_wdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr.sv
// Two-way round-robin picker; the pointer remembers the last granted requester.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic       win
);

  logic last_q;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    win = 1'b0;
    case (req)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_q;
      default: win = 1'b0;
    endcase
  end

  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  last_q <= 1'b1;
    else if (en) last_q <= win;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between two requesters (IDLE -> CMD -> [RESP]).
// Optional RAM_ARB_STATS_EN adds saturating per-requester grant counters.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  ram_port_arbiter_if.slave bus,
`ifdef RAM_ARB_STATS_EN
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1,
`endif
  output arb_state_t        dbg_state
);

  arb_state_t        state_q, state_nxt;
  logic [1:0]        req_vec;
  logic              any_req, arb_en, win;
  logic              sel_q;
  logic [1:0]        gnt_q, rvalid_q;
  logic              ram_we_q, ram_re_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;

  assign req_vec = {bus.req1, bus.req0};
  assign any_req = |req_vec;
  assign arb_en  = (state_q == ST_IDLE) && any_req;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_vec),
    .en    (arb_en),
    .win   (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_nxt = ST_CMD;
      ST_CMD:  state_nxt = ram_we_q ? ST_IDLE : ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command is registered in IDLE so it is on the RAM pins for exactly the CMD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= 1'b0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      if (arb_en) begin
        sel_q       <= win;
        gnt_q       <= win ? 2'b10 : 2'b01;
        ram_we_q    <= win ? bus.we1 : bus.we0;
        ram_re_q    <= win ? ~bus.we1 : ~bus.we0;
        ram_addr_q  <= win ? bus.addr1 : bus.addr0;
        ram_wdata_q <= win ? bus.wdata1 : bus.wdata0;
      end else begin
        gnt_q    <= 2'b00;
        ram_we_q <= 1'b0;
        ram_re_q <= 1'b0;
      end
      rvalid_q <= ((state_q == ST_CMD) && ram_re_q) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  assign bus.gnt0      = gnt_q[0];
  assign bus.gnt1      = gnt_q[1];
  assign bus.rvalid0   = rvalid_q[0];
  assign bus.rvalid1   = rvalid_q[1];
  assign bus.rdata0    = rvalid_q[0] ? bus.ram_rdata : '0;
  assign bus.rdata1    = rvalid_q[1] ? bus.ram_rdata : '0;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_re    = ram_re_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign dbg_state     = state_q;

`ifdef RAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt_q[0]) gnt_cnt0 <= sat_inc(gnt_cnt0);
      if (gnt_q[1]) gnt_cnt1 <= sat_inc(gnt_cnt1);
    end
  end
`endif

endmodule
